// File: rtl/cocc_pkg.sv
// Shared definitions for the serial loader and the downstream register stage.
package cocc_pkg;

    localparam int unsigned CoCC_WIDTH = 8;

    typedef enum logic {
        ST_DATA = 1'b0,
        ST_PAR  = 1'b1
    } state_t;

endpackage

// File: rtl/serial_byte_loader.sv
// Serial-to-parallel word assembler with optional parity; emits each completed
// word on data_out with a one-cycle load pulse for the downstream register.
module serial_byte_loader
    import cocc_pkg::*;
#(
    parameter int unsigned WIDTH      = CoCC_WIDTH,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] data_out,
    output logic             load,
    output logic             parity_err,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             load_q, load_d;
    logic             perr_q, perr_d;
    logic [WIDTH-1:0] shifted;
    logic             last_bit;

    assign shifted  = MSB_FIRST ? {sh_q[WIDTH-2:0], bit_in} : {bit_in, sh_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_DATA;
            cnt_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            load_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            load_q  <= load_d;
            perr_q  <= perr_d;
        end
    end

    // sync only clears frame assembly; data_out/parity_err and an already
    // registered load pulse are left alone.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        data_d  = data_q;
        load_d  = 1'b0;
        perr_d  = perr_q;
        if (sync) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            sh_d    = '0;
        end else if (bit_valid) begin
            unique case (state_q)
                ST_DATA: begin
                    sh_d = shifted;
                    if (last_bit) begin
                        cnt_d = '0;
                        if (PARITY_EN) begin
                            state_d = ST_PAR;
                        end else begin
                            data_d = shifted;
                            load_d = 1'b1;
                            perr_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_PAR: begin
                    data_d  = sh_q;
                    load_d  = 1'b1;
                    perr_d  = ((^sh_q) ^ bit_in) != PARITY_ODD;
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
                default: state_d = ST_DATA;
            endcase
        end
    end

    assign data_out   = data_q;
    assign load       = load_q;
    assign parity_err = perr_q;
    assign busy       = (cnt_q != '0) || (state_q == ST_PAR);

endmodule

// File: tb/tb_serial_byte_loader.sv
// Directed bench for serial_byte_loader: MSB-first, LSB-first and parity variants.
module tb_serial_byte_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bit_in, bit_valid, sync;
    logic [7:0] data0, data1, data2;
    logic       load0, load1, load2;
    logic       perr0, perr1, perr2;
    logic       busy0, busy1, busy2;

    int checks   = 0;
    int failures = 0;

    int lc0 = 0, lc2 = 0, dbl0 = 0;
    logic prev0 = 1'b0;

    always #5 clk = ~clk;

    serial_byte_loader #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sync(sync),
        .data_out(data0), .load(load0), .parity_err(perr0), .busy(busy0));

    serial_byte_loader #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sync(sync),
        .data_out(data1), .load(load1), .parity_err(perr1), .busy(busy1));

    serial_byte_loader #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_par (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sync(sync),
        .data_out(data2), .load(load2), .parity_err(perr2), .busy(busy2));

    always @(negedge clk) begin
        if (load0) lc0++;
        if (load0 && prev0) dbl0++;
        prev0 = load0;
        if (load2) lc2++;
    end

    typedef struct {
        logic [7:0] word;
        bit         gaps;
        logic [7:0] exp_msb;
        logic [7:0] exp_lsb;
    } vec_t;

    vec_t vecs[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    task automatic do_sync();
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        idle(2);
    endtask

    initial begin
        int b0, b2, d0;
        logic [7:0] w;

        vecs[0] = '{word: 8'hC5, gaps: 1'b0, exp_msb: 8'hC5, exp_lsb: 8'hA3};
        vecs[1] = '{word: 8'hC5, gaps: 1'b1, exp_msb: 8'hC5, exp_lsb: 8'hA3};
        vecs[2] = '{word: 8'h12, gaps: 1'b1, exp_msb: 8'h12, exp_lsb: 8'h48};

        rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; sync = 1'b0;
        idle(2);
        chk("reset_data", {24'd0, data0}, 32'd0);
        chk("reset_load", {31'd0, load0}, 32'd0);
        chk("reset_busy", {31'd0, busy0}, 32'd0);
        chk("reset_perr", {31'd0, perr2}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        for (int v = 0; v < 3; v++) begin
            do_sync();
            b0 = lc0; b2 = lc2; d0 = dbl0;
            for (int i = 7; i >= 0; i--) begin
                if (vecs[v].gaps) idle($urandom_range(0, 5));
                if (i == 0) chk("busy_mid_frame", {31'd0, busy0}, 32'd1);
                send_bit(vecs[v].word[i]);
            end
            chk("load_after_last", {31'd0, load0}, 32'd1);
            chk("busy_falls_with_load", {31'd0, busy0}, 32'd0);
            chk("lsb_load_after_last", {31'd0, load1}, 32'd1);
            idle(3);
            chk("load_count", lc0 - b0, 32'd1);
            chk("load_single_cycle", dbl0 - d0, 32'd0);
            chk("data_msb_first", {24'd0, data0}, {24'd0, vecs[v].exp_msb});
            chk("data_lsb_first", {24'd0, data1}, {24'd0, vecs[v].exp_lsb});
            chk("par_no_load_at_8", lc2 - b2, 32'd0);
            chk("par_busy_in_par", {31'd0, busy2}, 32'd1);
            chk("perr_zero_no_parity", {31'd0, perr0}, 32'd0);
        end

        // Parity frames: 0xC5 has four ones, so even parity bit is 0
        for (int p = 0; p < 2; p++) begin
            do_sync();
            b2 = lc2;
            w = 8'hC5;
            for (int i = 7; i >= 0; i--) send_bit(w[i]);
            idle(2);
            chk("par_no_load_data_only", lc2 - b2, 32'd0);
            send_bit(p[0]);
            chk("par_load_pulse", {31'd0, load2}, 32'd1);
            chk("par_busy_clear", {31'd0, busy2}, 32'd0);
            idle(2);
            chk("par_load_count", lc2 - b2, 32'd1);
            chk("par_data", {24'd0, data2}, 32'h000000C5);
            chk("par_err", {31'd0, perr2}, {31'd0, p[0]});
        end

        // Sync mid-frame together with a valid bit
        do_sync();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("sync_pre_busy", {31'd0, busy0}, 32'd1);
        b0 = lc0;
        sync = 1'b1; bit_in = 1'b1; bit_valid = 1'b1;
        @(negedge clk);
        sync = 1'b0; bit_valid = 1'b0;
        chk("sync_busy_clear", {31'd0, busy0}, 32'd0);
        chk("sync_no_load", {31'd0, load0}, 32'd0);
        w = 8'h5A;
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        chk("sync_data_held", {24'd0, data0}, 32'h000000C5);
        send_bit(w[0]);
        idle(2);
        chk("sync_load_count", lc0 - b0, 32'd1);
        chk("sync_data_msb", {24'd0, data0}, 32'h0000005A);
        chk("sync_data_lsb", {24'd0, data1}, 32'h0000005A);

        // Back-to-back frames then asynchronous reset mid-frame
        do_sync();
        b0 = lc0; d0 = dbl0;
        w = 8'hFF;
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
        chk("b2b_first_load", {31'd0, load0}, 32'd1);
        chk("b2b_first_data", {24'd0, data0}, 32'h000000FF);
        w = 8'h01;
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
        chk("b2b_second_load", {31'd0, load0}, 32'd1);
        chk("b2b_second_data", {24'd0, data0}, 32'h00000001);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        idle(2);
        chk("b2b_load_count", lc0 - b0, 32'd2);
        chk("b2b_no_double", dbl0 - d0, 32'd0);
        chk("b2b_busy_third", {31'd0, busy0}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_data", {24'd0, data0}, 32'd0);
        chk("async_rst_busy", {31'd0, busy0}, 32'd0);
        chk("async_rst_load", {31'd0, load0}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/serial_byte_loader.md
Name: serial_byte_loader

Overview:
- Upstream feeder for the 8-bit enable-gated register stage.
- Assembles a serial bit stream into a WIDTH-bit word.
- Emits the word on `data_out` with a one-cycle `load` pulse. `load` drives the downstream register's `en` and `data_out` drives its `in`.
- Supports an optional parity bit per frame, a synchronous frame restart, and a busy indication.

Parameters:
- WIDTH, 8: data bits per frame, legal range 2..16.
- MSB_FIRST, 1: 1 means the first received bit lands in data_out[WIDTH-1]; 0 means it lands in data_out[0].
- PARITY_EN, 0: 1 means each frame carries one extra parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity. Ignored when PARITY_EN=0.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous, active-low reset.
- bit_in, input, 1: serial data bit, sampled only when bit_valid=1.
- bit_valid, input, 1: qualifies bit_in for one cycle.
- sync, input, 1: synchronous frame restart.
- data_out, output, WIDTH: last completed word; held between loads.
- load, output, 1: one-cycle pulse when data_out updates. Connects to the downstream register's en.
- parity_err, output, 1: parity result of the last completed frame.
- busy, output, 1: a frame is partially received.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - data_out=0, load=0, parity_err=0, busy=0.
  - Shift register and bit counter are cleared; state is DATA.
- States:
  - DATA: accepting data bits. The counter cnt runs 0..WIDTH-1.
  - PAR: accepting the parity bit. Entered only when PARITY_EN=1.
- In DATA, on an edge where bit_valid=1:
  - MSB_FIRST=1: shift left, bit_in enters the LSB.
  - MSB_FIRST=0: shift right, bit_in enters the MSB.
  - cnt increments.
- Completion of the WIDTH-th data bit (cnt==WIDTH-1 and bit_valid=1):
  - PARITY_EN=0: at that same edge, data_out takes the assembled word, load=1 for the following cycle only, and cnt returns to 0.
  - PARITY_EN=1: go to PAR and do not load yet.
- In PAR, on an edge where bit_valid=1:
  - data_out takes the assembled word and load=1 for one cycle.
  - parity_err = (XOR of data bits XOR bit_in) != PARITY_ODD. Even parity with a correct bit gives 0.
  - Return to DATA with cnt=0.
- parity_err holds its value until the next load. It is always 0 when PARITY_EN=0.
- Latency: load is high in the cycle after the edge that sampled the final bit. This is exactly one pulse per frame, never two consecutive cycles.
- Back-to-back frames: a bit_valid in the cycle where load=1 is accepted as bit 0 of the next frame.
- bit_valid=0: nothing changes; gaps of any length between bits are allowed.
- sync=1: at the edge, cnt=0, shift register=0, state=DATA.
  - sync has priority over a simultaneous bit_valid; that bit is discarded.
  - data_out, parity_err and any load already scheduled for this cycle are unaffected.
  - sync never generates a load.
- busy = (cnt!=0) or (state==PAR). It is a registered-state decode with no combinational path from inputs.
- Reset mid-frame discards the partial frame and data_out returns to 0.

Decomposition:
- Shared package cocc_pkg holds:
  - the state encoding localparams ST_DATA=1'b0 and ST_PAR=1'b1;
  - the default word width constant CoCC_WIDTH=8, which is shared with the register stage.
- Counter width is $clog2(WIDTH) and is local to the block.
- No sub-module: the shift, count and parity logic is small and tightly coupled.

Test Plan:
- Reset, then MSB_FIRST=1 with bits 1,1,0,0,0,1,0,1 on consecutive cycles -> load pulses once, data_out=8'hC5, busy falls with the load.
- MSB_FIRST=0 with the same bit sequence -> data_out=8'hA3.
- Send the same bits with random 0..5-cycle gaps in bit_valid -> data_out=8'hC5 and load is asserted for exactly 1 cycle.
- PARITY_EN=1, PARITY_ODD=0:
  - 0xC5 followed by parity 0 -> load, parity_err=0.
  - Then 0xC5 followed by parity 1 -> parity_err=1.
  - No load after only 8 bits in either case.
- Send 3 bits, then assert sync together with bit_valid, then 8 bits of 0x5A -> data_out=8'h5A.
  - No load at the sync.
  - The previous data_out is held until 0x5A completes.
- Two back-to-back frames 0xFF and 0x01 with no gap, then assert rst_n=0 mid-way through a third frame:
  - Two separate load pulses, with data_out=8'hFF then 8'h01.
  - After reset, data_out=0, busy=0 and load=0 immediately, asynchronously.
